// File: rtl/esp_uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a built-in 8N1 UART serializer.
// A winning requester holds the line until its last-flagged byte has been sent.
module esp_uart_tx_arbiter #(
   parameter int CLKS_PER_BIT = 434,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic       txd,
   output logic       busy,
   output logic [1:0] grant,
   output logic       timeout_pulse
);

   localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [15:0]     BAUD_MAX = 16'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state, state_nxt;
   logic            owner, lock, last_winner, last_flag;
   logic [7:0]      shift;
   logic [2:0]      bit_cnt;
   logic [15:0]     baud_cnt;
   logic [TO_W-1:0] to_cnt;

   logic            pref, pref_valid, pick;
   logic            accept, acc_id, acc_last, owner_valid, bit_done, to_fire;
   logic [7:0]      acc_data;

   assign bit_done    = (baud_cnt == BAUD_MAX);
   assign owner_valid = owner ? s1_valid : s0_valid;

   // The requester that did not win last time is preferred; the other only gets a turn if it is alone.
   assign pref       = ~last_winner;
   assign pref_valid = pref ? s1_valid : s0_valid;
   assign pick       = pref_valid ? pref : ~pref;

   // NOTE: every output of this block gets a default first, so no path through it can infer a latch.
   always_comb begin
      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      state_nxt = state;
      if (state == S_IDLE) begin
         if (lock) begin
            s0_ready = (owner == 1'b0);
            s1_ready = (owner == 1'b1);
         end else if (s0_valid | s1_valid) begin
            s0_ready = (pick == 1'b0);
            s1_ready = (pick == 1'b1);
         end
      end
      accept = (s0_valid & s0_ready) | (s1_valid & s1_ready);
      unique case (state)
         S_IDLE:  if (accept) state_nxt = S_START;
         S_START: if (bit_done) state_nxt = S_DATA;
         S_DATA:  if (bit_done && bit_cnt == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (bit_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign acc_id   = s1_valid & s1_ready;
   assign acc_data = acc_id ? s1_data : s0_data;
   assign acc_last = acc_id ? s1_last : s0_last;
   assign to_fire  = (LOCK_TIMEOUT != 0) && (state == S_IDLE) && lock && !owner_valid
                     && (to_cnt == TO_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner         <= 1'b0;
         lock          <= 1'b0;
         last_winner   <= 1'b1;
         last_flag     <= 1'b0;
         shift         <= '0;
         bit_cnt       <= '0;
         baud_cnt      <= '0;
         to_cnt        <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= to_fire;
         if (state == S_IDLE || bit_done) baud_cnt <= '0;
         else                             baud_cnt <= baud_cnt + 16'd1;

         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  shift     <= acc_data;
                  last_flag <= acc_last;
                  owner     <= acc_id;
                  lock      <= ~acc_last;
                  bit_cnt   <= '0;
                  to_cnt    <= '0;
               end else if (to_fire) begin
                  lock        <= 1'b0;
                  last_winner <= owner;
                  to_cnt      <= '0;
               end else if (lock && !owner_valid && LOCK_TIMEOUT != 0) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            S_STOP: begin
               if (bit_done && last_flag) begin
                  lock        <= 1'b0;
                  last_winner <= owner;
               end
            end
            default: ;
         endcase
      end
   end

   // Decoded straight from state so an asynchronous reset drives the line idle at once.
   always_comb begin
      txd = 1'b1;
      if (state == S_START)     txd = 1'b0;
      else if (state == S_DATA) txd = shift[0];
   end

   assign busy  = (state != S_IDLE);
   assign grant = (busy || lock) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
